// File: rtl/mux8_pkg.sv
// Shared types and helpers for the registered 8:1 word multiplexer.
package mux8_pkg;

  localparam int unsigned NUM_IN = 8;
  localparam int unsigned SEL_W  = 3;

  typedef logic [SEL_W-1:0] sel_t;

  function automatic logic [NUM_IN-1:0] onehot8(sel_t sel);
    logic [NUM_IN-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux8_comb.sv
// Purely combinational 8:1 select of WIDTH-bit words.
module mux8_comb
  import mux8_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] d [NUM_IN],
  input  logic [SEL_W-1:0] s,
  output logic [WIDTH-1:0] y
);

  // Every 3-bit select value is a legal index, so there is no out-of-range path.
  always_comb begin
    y = d[0];
    unique case (s)
      3'd0: y = d[0];
      3'd1: y = d[1];
      3'd2: y = d[2];
      3'd3: y = d[3];
      3'd4: y = d[4];
      3'd5: y = d[5];
      3'd6: y = d[6];
      3'd7: y = d[7];
      default: y = d[0];
    endcase
  end

endmodule

// File: rtl/mux8_reg.sv
// Registered 8:1 word multiplexer with valid strobe, captured select and its one-hot decode.
module mux8_reg
  import mux8_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [WIDTH-1:0]   d [NUM_IN],
  input  logic [SEL_W-1:0]   s,
  output logic [WIDTH-1:0]   y_comb,
  output logic [WIDTH-1:0]   y,
  output logic               y_valid,
  output logic [SEL_W-1:0]   sel_q,
  output logic [NUM_IN-1:0]  sel_onehot
);

  logic [WIDTH-1:0]  y_d, y_q;
  logic [SEL_W-1:0]  sel_d, sel_r_q;
  logic [NUM_IN-1:0] oh_d, oh_q;
  logic              valid_d, valid_q;

  mux8_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .d (d),
    .s (s),
    .y (y_comb)
  );

  always_comb begin
    y_d     = y_q;
    sel_d   = sel_r_q;
    oh_d    = oh_q;
    valid_d = en;
    if (en) begin
      y_d   = y_comb;
      sel_d = s;
      oh_d  = onehot8(s);
    end
  end

  // Reset one-hot matches the reset select of zero so exactly one bit is always set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q     <= '0;
      sel_r_q <= '0;
      oh_q    <= 8'h01;
      valid_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      sel_r_q <= sel_d;
      oh_q    <= oh_d;
      valid_q <= valid_d;
    end
  end

  assign y          = y_q;
  assign sel_q      = sel_r_q;
  assign sel_onehot = oh_q;
  assign y_valid    = valid_q;

endmodule

// File: tb/tb_mux8_reg.sv
// Directed bench for mux8_reg at WIDTH=4 and WIDTH=8 with a capture scoreboard.
module tb_mux8_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_a, en_b;
  logic [3:0] d_a [8];
  logic [7:0] d_b [8];
  logic [2:0] s_a, s_b;

  logic [3:0] y_comb_a, y_a;
  logic [7:0] y_comb_b, y_b;
  logic       y_valid_a, y_valid_b;
  logic [2:0] sel_q_a, sel_q_b;
  logic [7:0] oh_a, oh_b;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [7:0] y;
    logic [2:0] sel;
    logic [7:0] oh;
    logic       valid;
  } exp_t;

  exp_t sb [$];

  always #5 clk = ~clk;

  mux8_reg #(.WIDTH(4)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en_a),
    .d          (d_a),
    .s          (s_a),
    .y_comb     (y_comb_a),
    .y          (y_a),
    .y_valid    (y_valid_a),
    .sel_q      (sel_q_a),
    .sel_onehot (oh_a)
  );

  mux8_reg #(.WIDTH(8)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en_b),
    .d          (d_b),
    .s          (s_b),
    .y_comb     (y_comb_b),
    .y          (y_b),
    .y_valid    (y_valid_b),
    .sel_q      (sel_q_b),
    .sel_onehot (oh_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: a capture of word yv at select sv shows up one edge later.
  task automatic push_exp(input logic [7:0] yv, input logic [2:0] sv);
    exp_t e;
    logic [7:0] one;
    one     = 8'h01;
    e.y     = yv;
    e.sel   = sv;
    e.oh    = one << sv;
    e.valid = 1'b1;
    sb.push_back(e);
  endtask

  task automatic check_cap(input string tag, input bit use_b);
    exp_t e;
    n_checks++;
    assert (sb.size() != 0) else begin
      n_errors++;
      $error("FAIL %s: scoreboard empty, observed none expected one entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (use_b) begin
        check({tag, ".y"}, 32'(y_b), 32'(e.y));
        check({tag, ".sel_q"}, 32'(sel_q_b), 32'(e.sel));
        check({tag, ".onehot"}, 32'(oh_b), 32'(e.oh));
        check({tag, ".valid"}, 32'(y_valid_b), 32'(e.valid));
      end else begin
        check({tag, ".y"}, 32'(y_a), 32'(e.y[3:0]));
        check({tag, ".sel_q"}, 32'(sel_q_a), 32'(e.sel));
        check({tag, ".onehot"}, 32'(oh_a), 32'(e.oh));
        check({tag, ".valid"}, 32'(y_valid_a), 32'(e.valid));
      end
    end
  endtask

  initial begin
    logic [2:0] order [8];
    order = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

    rst_n = 1'b0;
    en_a  = 1'b1;
    en_b  = 1'b0;
    s_a   = 3'd5;
    s_b   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      d_a[i] = 4'(8 + i);
      d_b[i] = 8'hA0 | 8'(i);
    end

    // Reset held across edges with en high.
    #12;
    check("rst.y", 32'(y_a), 32'h0);
    check("rst.valid", 32'(y_valid_a), 32'h0);
    check("rst.sel_q", 32'(sel_q_a), 32'h0);
    check("rst.onehot", 32'(oh_a), 32'h01);
    check("rst.y_comb", 32'(y_comb_a), 32'hD);
    tick();
    check("rst_edge.y", 32'(y_a), 32'h0);
    check("rst_edge.onehot", 32'(oh_a), 32'h01);

    // Full sweep, one select per cycle.
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      s_a = order[k];
      push_exp(8'(8 + int'(order[k])), order[k]);
      #1;
      check($sformatf("sweep%0d.y_comb", k), 32'(y_comb_a), 32'(8 + int'(order[k])));
      tick();
      check_cap($sformatf("sweep%0d", k), 1'b0);
    end

    // Hold with en low.
    s_a = 3'd3;
    push_exp(8'h0B, 3'd3);
    tick();
    check_cap("hold_cap", 1'b0);
    en_a   = 1'b0;
    s_a    = 3'd6;
    d_a[3] = 4'h0;
    #1;
    check("hold.y_comb", 32'(y_comb_a), 32'hE);
    check("hold.pre_y", 32'(y_a), 32'hB);
    check("hold.pre_valid", 32'(y_valid_a), 32'h1);
    tick();
    check("hold.y", 32'(y_a), 32'hB);
    check("hold.sel_q", 32'(sel_q_a), 32'h3);
    check("hold.onehot", 32'(oh_a), 32'h08);
    check("hold.valid", 32'(y_valid_a), 32'h0);
    d_a[3] = 4'hB;

    // Async reset mid-stream.
    en_a = 1'b1;
    s_a  = 3'd7;
    push_exp(8'h0F, 3'd7);
    tick();
    check_cap("pre_arst", 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.y", 32'(y_a), 32'h0);
    check("arst.valid", 32'(y_valid_a), 32'h0);
    check("arst.sel_q", 32'(sel_q_a), 32'h0);
    check("arst.onehot", 32'(oh_a), 32'h01);
    rst_n = 1'b1;
    s_a   = 3'd2;
    push_exp(8'h0A, 3'd2);
    tick();
    check_cap("post_arst", 1'b0);
    en_a = 1'b0;

    // WIDTH=8 instance: capture s=7, then disturb unselected words.
    en_b = 1'b1;
    s_b  = 3'd7;
    push_exp(8'hA7, 3'd7);
    tick();
    check_cap("w8_s7", 1'b1);
    en_b = 1'b0;
    for (int i = 0; i < 7; i++) d_b[i] = 8'h5A ^ 8'(i);
    #1;
    check("w8_dist.y_now", 32'(y_b), 32'hA7);
    tick();
    check("w8_dist.y_edge", 32'(y_b), 32'hA7);
    for (int i = 0; i < 8; i++) d_b[i] = 8'hA0 | 8'(i);

    en_b = 1'b1;
    s_b  = 3'd0;
    push_exp(8'hA0, 3'd0);
    tick();
    check_cap("w8_s0", 1'b1);
    d_b[7] = 8'h00;
    d_b[3] = 8'hFF;
    tick();
    check("w8_unsel.y", 32'(y_b), 32'hA0);
    check("w8_unsel.onehot", 32'(oh_b), 32'h01);
    en_b = 1'b0;
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mux8_reg.md
Name: mux8_reg

Overview:
- Registered 8-to-1 multiplexer: selects one of eight WIDTH-bit data words with a 3-bit binary select.
- Presents the chosen word on a registered output after one clock, plus a zero-latency combinational output for local paths.
- Sits in datapaths that need a pipelined word select with a valid strobe and a one-hot decode of the select used.

Parameters:
- WIDTH, 4, bit width of each data input and of both outputs.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  capture enable; when high, the selected word is registered this cycle.
- d  input  8 x WIDTH  unpacked array of data words d[0]..d[7].
- s  input  3  binary select; s[2] is MSB, s[0] is LSB.
- y_comb  output  WIDTH  combinational d[s].
- y  output  WIDTH  registered selected word.
- y_valid  output  1  high for exactly the cycles following an en-high capture.
- sel_q  output  3  select value captured with y.
- sel_onehot  output  8  registered one-hot decode of sel_q; bit k high iff sel_q==k.

Behaviour:
- Combinational path:
  - y_comb = d[s] at all times, including during reset.
  - No X propagation for any of the 8 legal s values; every 3-bit value is legal, so there is no out-of-range case.
- Reset: while rst_n=0, regardless of clk:
  - y = 0, y_valid = 0, sel_q = 0, sel_onehot = 8'b0000_0001.
  - Deassertion takes effect at the next rising clk edge.
- Rising clk edge with en=1:
  - y <= d[s]; sel_q <= s; sel_onehot <= 1<<s; y_valid <= 1.
  - Latency from d/s to y is exactly one cycle.
- Rising clk edge with en=0:
  - y, sel_q and sel_onehot hold their values; y_valid <= 0.
- Select or data changing on consecutive cycles with en=1 produces a new y every cycle. There are no bubbles and no backpressure.
- Data change while en=0:
  - Does not affect y.
  - Is reflected immediately on y_comb.
- Reset asserted mid-stream: all registered outputs clear immediately (asynchronously). The first capture after release happens on the first edge with rst_n=1 and en=1.
- Invariant: sel_onehot always has exactly one bit set, and y == d[sel_q] as sampled at the capture edge.
- Implementation rules:
  - Use an indexed select, or an equivalent case over s covering all 8 values with a default that assigns d[0].
  - Create no latches.

Decomposition:
- Shared package mux8_pkg:
  - localparam NUM_IN = 8.
  - localparam SEL_W = 3.
  - typedef logic [SEL_W-1:0] sel_t.
  - Function onehot8(sel_t) returning logic [7:0].
- Natural sub-module: mux8_comb, a purely combinational WIDTH-parameterized 8:1 select (d, s -> y). mux8_reg instantiates it and adds the register stage, valid and one-hot decode.

Test Plan:
- Reset check: load d[i] = 4'b1000 + i (8..15), hold rst_n=0 with en=1 and s=5.
  - Required during reset: y=0, y_valid=0, sel_q=0, sel_onehot=8'h01, while y_comb=4'hD.
- Full sweep: same d, en=1, s applied in order 0,4,2,6,1,5,3,7, one value per cycle.
  - Required on y, each one cycle later: 8,12,10,14,9,13,11,15.
  - Required on sel_onehot, in the same cycles: 01,10,04,40,02,20,08,80.
  - y_valid stays 1 throughout.
- Hold: capture s=3 (y=4'hB), then drop en and change s to 6 and d[3] to 0.
  - Required: y stays 4'hB, sel_q stays 3, y_valid falls to 0 after one cycle.
  - Required: y_comb follows to 4'hE.
- Async reset mid-stream: during the sweep at s=7, pulse rst_n low between clock edges.
  - Required: y drops to 0 immediately, without waiting for a clock edge.
  - Required: the first edge after release with s=2 gives y=4'hA, y_valid=1.
- Width and data independence, WIDTH=8: d[i] = 8'hA0 | i, s=7 then s=0.
  - Required on y: 8'hA7 then 8'hA0.
  - Changing unselected words between edges must never alter y.
